// File: rtl/qam_symbol_upsampler.sv
// Symbol upsampler between a QAM mapper and a DAC/pulse-shaping filter.
// Buffers symbols in a FIFO and emits sps+1 samples per symbol (repeated or zero-stuffed).
module qam_symbol_upsampler #(
    parameter int FIFO_DEPTH = 8,
    parameter int DATA_W     = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [DATA_W-1:0]             symbol_in,
    input  logic                          valid_in,
    output logic                          ready_out,
    input  logic [2:0]                    sps,
    input  logic                          zero_stuff,
    output logic [DATA_W-1:0]             sample_out,
    output logic                          valid_out,
    input  logic                          ready_in,
    output logic [$clog2(FIFO_DEPTH):0]   fill_level,
    output logic                          overflow,
    output logic                          underflow
);

    localparam int AW = $clog2(FIFO_DEPTH);

    // Handshakes: a symbol transfers on a rising edge with valid_in && ready_out;
    // a sample transfers on a rising edge with valid_out && ready_in. Neither
    // valid depends combinationally on its matching ready.

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    state_t state, state_next;

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [AW:0]       count;
    logic [AW:0]       count_next;

    logic [DATA_W-1:0] sym_q;
    logic [2:0]        sps_q;
    logic              zs_q;
    logic [2:0]        phase;

    logic push;
    logic pop;
    logic advance;
    logic empty;
    logic last_sample;
    logic go_idle;

    assign push        = valid_in && ready_out;
    assign empty       = (count == '0);
    assign last_sample = (phase == sps_q);

    always_comb begin
        state_next = state;
        pop        = 1'b0;
        advance    = 1'b0;
        go_idle    = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) begin
                    pop        = 1'b1;
                    state_next = EMIT;
                end
            end
            EMIT: begin
                if (ready_in) begin
                    if (!last_sample) begin
                        advance = 1'b1;
                    end else if (!empty) begin
                        pop = 1'b1;
                    end else begin
                        go_idle    = 1'b1;
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        count_next = count;
        case ({push, pop})
            2'b10:   count_next = count + 1'b1;
            2'b01:   count_next = count - 1'b1;
            default: count_next = count;
        endcase
    end

    // Storage carries no reset; emptiness is defined by the pointers and count.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= symbol_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            ready_out <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count_next;
            // Registered from the post-edge occupancy, so a same-cycle pop never admits a push while full.
            ready_out <= (count_next < (AW+1)'(FIFO_DEPTH));
            if (valid_in && !ready_out) begin
                overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            sym_q     <= '0;
            sps_q     <= '0;
            zs_q      <= 1'b0;
            phase     <= '0;
            underflow <= 1'b0;
        end else begin
            state <= state_next;
            if (pop) begin
                sym_q <= mem[rd_ptr];
                sps_q <= sps;
                zs_q  <= zero_stuff;
                phase <= '0;
            end else if (advance) begin
                phase <= phase + 1'b1;
            end
            if (go_idle) begin
                underflow <= 1'b1;
            end
        end
    end

    assign valid_out  = (state == EMIT);
    assign sample_out = (valid_out && (phase == '0 || !zs_q)) ? sym_q : '0;
    assign fill_level = count;

endmodule

// File: tb/tb_qam_symbol_upsampler.sv
// Self-checking bench for qam_symbol_upsampler: directed scenarios plus a
// randomized run scored against a sample-sequence model.
module tb_qam_symbol_upsampler;

  localparam int DEPTH = 8;
  localparam int W     = 32;
  localparam int FW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic [W-1:0]  symbol_in;
  logic          valid_in;
  logic          ready_out;
  logic [2:0]    sps;
  logic          zero_stuff;
  logic [W-1:0]  sample_out;
  logic          valid_out;
  logic          ready_in;
  logic [FW-1:0] fill_level;
  logic          overflow;
  logic          underflow;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];

  qam_symbol_upsampler #(.FIFO_DEPTH(DEPTH), .DATA_W(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .symbol_in  (symbol_in),
    .valid_in   (valid_in),
    .ready_out  (ready_out),
    .sps        (sps),
    .zero_stuff (zero_stuff),
    .sample_out (sample_out),
    .valid_out  (valid_out),
    .ready_in   (ready_in),
    .fill_level (fill_level),
    .overflow   (overflow),
    .underflow  (underflow)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    valid_in = 1'b0;
    ready_in = 1'b0;
    #1;
    tick();
    rst = 1'b0;
    tick();
  endtask

  // reference model: one accepted symbol expands to sps+1 samples
  task automatic expect_symbol(input logic [W-1:0] s, input int n_sps, input bit zs);
    logic [W-1:0] v;
    for (int i = 0; i <= n_sps; i++) begin
      v = (zs && i > 0) ? '0 : s;
      exp_q.push_back(v);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    valid_in = 1'b0;
    ready_in = 1'b0;
    symbol_in = '0;
    sps = '0;
    zero_stuff = 1'b0;
    #2;
    checks++;
    if (fill_level !== '0 || ready_out !== 1'b0 || valid_out !== 1'b0 || sample_out !== '0 ||
        overflow !== 1'b0 || underflow !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: fill=%0d ready_out=%b valid_out=%b sample=%h ovf=%b unf=%b, want all zero",
               fill_level, ready_out, valid_out, sample_out, overflow, underflow);
    end
    tick();
    rst = 1'b0;
    checks++;
    if (ready_out !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready_low: ready_out=%b want 0 before first edge after release", ready_out);
    end
    tick();
    checks++;
    if (ready_out !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready_rise: ready_out=%b want 1 one edge after release", ready_out);
    end
  endtask

  task automatic test_repeat;
    logic [W-1:0] s;
    s = 32'h0001_0002;
    do_reset();
    sps = 3'd3;
    zero_stuff = 1'b0;
    ready_in = 1'b1;
    valid_in = 1'b1;
    symbol_in = s;
    tick();
    valid_in = 1'b0;
    checks++;
    if (valid_out !== 1'b0 || fill_level !== FW'(1)) begin
      errors++;
      $display("FAIL latency_accept: valid_out=%b fill=%0d want 0 and 1", valid_out, fill_level);
    end
    tick();
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (valid_out !== 1'b1 || sample_out !== s) begin
        errors++;
        $display("FAIL repeat_sample%0d: valid_out=%b sample=%h want 1 and %h", i, valid_out, sample_out, s);
      end
      tick();
    end
    checks++;
    if (valid_out !== 1'b0 || underflow !== 1'b1 || sample_out !== '0) begin
      errors++;
      $display("FAIL repeat_end: valid_out=%b underflow=%b sample=%h want 0 1 0", valid_out, underflow, sample_out);
    end
  endtask

  task automatic test_zero_stuff_back_to_back;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] want [4];
    a = $urandom | 32'h1;
    b = $urandom | 32'h100;
    want[0] = a;
    want[1] = '0;
    want[2] = b;
    want[3] = '0;
    do_reset();
    sps = 3'd1;
    zero_stuff = 1'b1;
    ready_in = 1'b1;
    valid_in = 1'b1;
    symbol_in = a;
    tick();
    symbol_in = b;
    tick();
    valid_in = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (valid_out !== 1'b1 || sample_out !== want[i] || underflow !== 1'b0) begin
        errors++;
        $display("FAIL zs_b2b_sample%0d: valid_out=%b sample=%h underflow=%b want 1 %h 0",
                 i, valid_out, sample_out, underflow, want[i]);
      end
      tick();
    end
    checks++;
    if (valid_out !== 1'b0 || underflow !== 1'b1) begin
      errors++;
      $display("FAIL zs_b2b_end: valid_out=%b underflow=%b want 0 1", valid_out, underflow);
    end
  endtask

  task automatic test_overflow;
    int n_sps;
    bit zs;
    int cyc;
    logic [W-1:0] s;
    do_reset();
    exp_q.delete();
    n_sps = $urandom_range(0, 7);
    zs = 1'($urandom_range(0, 1));
    sps = 3'(n_sps);
    zero_stuff = zs;
    ready_in = 1'b0;
    for (int i = 0; i < 9; i++) begin
      s = $urandom;
      valid_in = 1'b1;
      symbol_in = s;
      expect_symbol(s, n_sps, zs);
      tick();
    end
    checks++;
    if (fill_level !== FW'(DEPTH) || ready_out !== 1'b0 || overflow !== 1'b0 || valid_out !== 1'b1) begin
      errors++;
      $display("FAIL full_state: fill=%0d ready_out=%b ovf=%b valid_out=%b want %0d 0 0 1",
               fill_level, ready_out, overflow, valid_out, DEPTH);
    end
    symbol_in = 32'hDEAD_BEEF;
    tick();
    valid_in = 1'b0;
    checks++;
    if (overflow !== 1'b1 || fill_level !== FW'(DEPTH)) begin
      errors++;
      $display("FAIL overflow_drop: ovf=%b fill=%0d want 1 %0d", overflow, fill_level, DEPTH);
    end
    ready_in = 1'b1;
    cyc = 0;
    while ((exp_q.size() > 0 || valid_out) && cyc < 200) begin
      if (valid_out) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL overflow_drain: unexpected sample %h, want none", sample_out);
        end else begin
          s = exp_q.pop_front();
          if (sample_out !== s) begin
            errors++;
            $display("FAIL overflow_drain: sample=%h want %h", sample_out, s);
          end
        end
      end
      tick();
      cyc++;
    end
    checks++;
    if (exp_q.size() != 0 || valid_out !== 1'b0) begin
      errors++;
      $display("FAIL overflow_drain_done: left=%0d valid_out=%b want 0 0", exp_q.size(), valid_out);
    end
    exp_q.delete();
  endtask

  task automatic test_sps_change;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] want;
    a = $urandom | 32'h1;
    b = $urandom | 32'h2;
    do_reset();
    sps = 3'd3;
    zero_stuff = 1'b0;
    ready_in = 1'b1;
    valid_in = 1'b1;
    symbol_in = a;
    tick();
    symbol_in = b;
    tick();
    valid_in = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i == 1) sps = 3'd0;
      want = (i < 4) ? a : b;
      checks++;
      if (valid_out !== 1'b1 || sample_out !== want) begin
        errors++;
        $display("FAIL sps_change_sample%0d: valid_out=%b sample=%h want 1 %h", i, valid_out, sample_out, want);
      end
      tick();
    end
    checks++;
    if (valid_out !== 1'b0) begin
      errors++;
      $display("FAIL sps_change_end: valid_out=%b want 0", valid_out);
    end
  endtask

  task automatic test_reset_mid_symbol;
    int bad;
    do_reset();
    sps = 3'd7;
    zero_stuff = 1'b0;
    ready_in = 1'b1;
    valid_in = 1'b1;
    for (int i = 0; i < 4; i++) begin
      symbol_in = $urandom | 32'h1;
      tick();
    end
    valid_in = 1'b0;
    checks++;
    if (valid_out !== 1'b1 || fill_level !== FW'(3)) begin
      errors++;
      $display("FAIL mid_pre_reset: valid_out=%b fill=%0d want 1 3", valid_out, fill_level);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (valid_out !== 1'b0 || fill_level !== '0 || sample_out !== '0 || ready_out !== 1'b0) begin
      errors++;
      $display("FAIL mid_async_reset: valid_out=%b fill=%0d sample=%h ready_out=%b want 0 0 0 0",
               valid_out, fill_level, sample_out, ready_out);
    end
    tick();
    rst = 1'b0;
    tick();
    checks++;
    if (ready_out !== 1'b1) begin
      errors++;
      $display("FAIL mid_ready_after_release: ready_out=%b want 1", ready_out);
    end
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      if (valid_out !== 1'b0 || sample_out !== '0) bad++;
      tick();
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL mid_no_stale: %0d cycles with output activity, want 0", bad);
    end
  endtask

  task automatic test_random;
    int accepted;
    int block;
    int blk_acc;
    int cur_sps;
    bit cur_zs;
    int cyc;
    bit acc;
    bit hs;
    logic [W-1:0] sym;
    logic [W-1:0] obs;
    logic [W-1:0] want;
    do_reset();
    exp_q.delete();
    accepted = 0;
    while (accepted < 10000) begin
      cur_sps = $urandom_range(0, 7);
      cur_zs = 1'($urandom_range(0, 1));
      sps = 3'(cur_sps);
      zero_stuff = cur_zs;
      block = $urandom_range(1, 64);
      if (block > 10000 - accepted) block = 10000 - accepted;
      blk_acc = 0;
      cyc = 0;
      while ((blk_acc < block || exp_q.size() > 0 || valid_out) && cyc < 5000) begin
        valid_in = (blk_acc < block) && ($urandom_range(0, 3) != 0);
        sym = $urandom;
        symbol_in = sym;
        ready_in = ($urandom_range(0, 7) != 0);
        #1;
        acc = valid_in && ready_out;
        hs = valid_out && ready_in;
        obs = sample_out;
        checks++;
        if (fill_level > FW'(DEPTH) || (!valid_out && sample_out !== '0)) begin
          errors++;
          $display("FAIL rand_invariant: fill=%0d valid_out=%b sample=%h want fill<=%0d and zero idle sample",
                   fill_level, valid_out, sample_out, DEPTH);
        end
        tick();
        cyc++;
        if (acc) begin
          expect_symbol(sym, cur_sps, cur_zs);
          blk_acc++;
        end
        if (hs) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL rand_sample: unexpected sample %h, want none", obs);
          end else begin
            want = exp_q.pop_front();
            if (obs !== want) begin
              errors++;
              $display("FAIL rand_sample: sample=%h want %h", obs, want);
            end
          end
        end
      end
      valid_in = 1'b0;
      if (cyc >= 5000) begin
        checks++;
        errors++;
        $display("FAIL rand_timeout: block stalled, %0d samples outstanding, want 0", exp_q.size());
        exp_q.delete();
        do_reset();
      end
      accepted += blk_acc;
    end
    ready_in = 1'b0;
  endtask

  initial begin
    test_reset();
    test_repeat();
    test_zero_stuff_back_to_back();
    test_overflow();
    test_sps_change();
    test_reset_mid_symbol();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #20000000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

endmodule
